// File: rtl/instr_issue_pkg.sv
// Shared types and sizing for the instruction issue unit.
package instr_issue_pkg;

  localparam int unsigned PROG_DEPTH = 16;
  localparam int unsigned RES_DEPTH  = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned IDX_W      = 4;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] mem;
    logic [IDX_W-1:0]  idx;
  } res_entry_t;

  localparam int unsigned RES_ENTRY_W = $bits(res_entry_t);

  // Clamp a requested run length to the program size.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len,
                                               input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular result FIFO; head is presented combinationally from storage.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 68
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer/count update; pushes into a full FIFO and pops from an empty one are dropped.
  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= push_data;
    end
  end

  // Head is forced to zero when empty so nothing stale is visible.
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? store_q[rd_ptr_q] : '0;
  assign full       = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/instr_issue_unit.sv
// Issues a stored program one word per cycle to a single-cycle CPU and queues its results.
module instr_issue_unit #(
  parameter int unsigned PROG_DEPTH = instr_issue_pkg::PROG_DEPTH,
  parameter int unsigned RES_DEPTH  = instr_issue_pkg::RES_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [31:0] prog_data,
  input  logic [4:0]  prog_len,
  input  logic        start,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic [31:0] aluResult,
  input  logic [31:0] memData,
  output logic        res_valid,
  output logic [31:0] res_alu,
  output logic [31:0] res_mem,
  output logic [3:0]  res_idx,
  input  logic        res_ready,
  output logic        busy,
  output logic        done
);

  import instr_issue_pkg::*;

  logic [WORD_W-1:0]      prog_mem_q [PROG_DEPTH];
  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       pc_q, pc_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       pc_inc;
  logic                   done_q, done_d;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   head_valid;
  res_entry_t             push_entry;
  res_entry_t             head_entry;
  logic [RES_ENTRY_W-1:0] head_bits;

  // Program memory is writable only while idle and survives reset.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) begin
      prog_mem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state, issue strobe and result push decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    done_d      = 1'b0;
    fifo_push   = 1'b0;
    instr_valid = 1'b0;
    instruction = NOP_WORD;
    pc_inc      = pc_q + LEN_W'(1);
    push_entry  = '{alu: aluResult, mem: memData, idx: pc_q[IDX_W-1:0]};
    case (state_q)
      IDLE: begin
        if (start && (prog_len != '0)) begin
          len_d   = sat_len(prog_len, LEN_W'(PROG_DEPTH));
          pc_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!fifo_full) begin
          instr_valid = 1'b1;
          instruction = prog_mem_q[pc_q[ADDR_W-1:0]];
          fifo_push   = 1'b1;
          pc_d        = pc_inc;
          if (pc_inc == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!fifo_full) begin
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, program counter, latched length and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign fifo_pop = head_valid && res_ready;

  result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (RES_ENTRY_W)
  ) u_result_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .head_data  (head_bits),
    .head_valid (head_valid),
    .full       (fifo_full)
  );

  assign head_entry = res_entry_t'(head_bits);
  assign res_valid  = head_valid;
  assign res_alu    = head_entry.alu;
  assign res_mem    = head_entry.mem;
  assign res_idx    = head_entry.idx;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Scoreboard bench for instr_issue_unit with a queue-level reference model.
module tb_instr_issue_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;
  logic [4:0]  prog_len;
  logic        start;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] aluResult;
  logic [31:0] memData;
  logic        res_valid;
  logic [31:0] res_alu;
  logic [31:0] res_mem;
  logic [3:0]  res_idx;
  logic        res_ready;
  logic        busy;
  logic        done;

  instr_issue_unit dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .aluResult   (aluResult),
    .memData     (memData),
    .res_valid   (res_valid),
    .res_alu     (res_alu),
    .res_mem     (res_mem),
    .res_idx     (res_idx),
    .res_ready   (res_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; logic [3:0] idx; } issue_t;
  typedef struct { logic [31:0] alu; logic [31:0] mem; logic [3:0] idx; } res_t;

  issue_t      exp_issue[$];   // words still to be issued in the current run
  res_t        exp_res[$];     // results the FIFO should hold, oldest first
  logic [31:0] mem_model [16];

  int checks = 0, errors = 0;
  int cyc = 0, issued_cnt = 0, first_cyc = -1, last_cyc = -1, done_cnt = 0;
  int prev_sz = 0, mon_sz;
  bit done_pending = 0, rand_ready = 0;
  issue_t mon_ie;
  res_t   mon_re;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fresh CPU results every cycle, optional random consumer back-pressure.
  always @(posedge clk) begin
    #2;
    aluResult = $urandom;
    memData   = $urandom;
    if (rand_ready) res_ready = ($urandom_range(0, 2) != 0);
  end

  // Monitor: compares every observed cycle against the queue model.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_sz = exp_res.size();
      chk("res_valid", res_valid, mon_sz != 0);
      chk("busy", busy, exp_issue.size() != 0);
      chk("done", done, done_pending);
      done_pending = 0;
      if (done) done_cnt++;
      if (res_valid && res_ready && mon_sz != 0) begin
        mon_re = exp_res.pop_front();
        chk("res_alu", res_alu, mon_re.alu);
        chk("res_mem", res_mem, mon_re.mem);
        chk("res_idx", res_idx, mon_re.idx);
      end
      if (instr_valid) begin
        chk("issue_pending", exp_issue.size() != 0, 1);
        chk("issue_not_full", mon_sz < DEPTH, 1);
        if (exp_issue.size() != 0) begin
          mon_ie = exp_issue.pop_front();
          chk("instruction", instruction, mon_ie.word);
          exp_res.push_back('{alu: aluResult, mem: memData, idx: mon_ie.idx});
          issued_cnt++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_issue.size() == 0) done_pending = 1;
        end
      end else begin
        chk("nop_when_invalid", instruction, 0);
        if (busy) chk("stall_only_when_full", (mon_sz == DEPTH) || (prev_sz == DEPTH), 1);
      end
      prev_sz = mon_sz;
    end
  end

  task automatic prog_write(input logic [3:0] a, input logic [31:0] d);
    bit active;
    step();
    active = (exp_issue.size() != 0) || busy;
    prog_we = 1; prog_addr = a; prog_data = d;
    step();
    prog_we = 0;
    if (!active) mem_model[a] = d;
  endtask

  task automatic run_start(input logic [4:0] len);
    bit active;
    int n;
    step();
    active = (exp_issue.size() != 0) || busy;
    start = 1; prog_len = len;
    step();
    start = 0;
    n = (len > 16) ? 16 : int'(len);
    if (!active) for (int i = 0; i < n; i++) exp_issue.push_back('{word: mem_model[i], idx: 4'(i)});
  endtask

  task automatic clear_stats();
    issued_cnt = 0; first_cyc = -1; last_cyc = -1; done_cnt = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (((exp_issue.size() != 0) || busy) && n < budget) begin
      step();
      n++;
    end
    chk("run_completes_in_budget", n < budget, 1);
    step();
  endtask

  task automatic drain();
    int n = 0;
    rand_ready = 0;
    res_ready = 1;
    while (exp_res.size() != 0 && n < 50) begin
      step();
      n++;
    end
    chk("fifo_drains_in_budget", n < 50, 1);
    step();
  endtask

  task automatic wait_issued(input int target);
    int n = 0;
    while (issued_cnt < target && n < 30) begin
      step();
      n++;
    end
    chk("issue_progress", issued_cnt >= target, 1);
  endtask

  initial begin
    reset = 1; prog_we = 0; prog_addr = 0; prog_data = 0; prog_len = 0;
    start = 0; aluResult = 0; memData = 0; res_ready = 0;
    #1 reset = 0;
    #2;
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    reset = 1;

    for (int i = 0; i < 16; i++) prog_write(4'(i), $urandom);
    prog_write(4'd0, 32'h7C01_1000);
    prog_write(4'd1, 32'h7801_1000);
    prog_write(4'd2, 32'h8401_1000);

    // Basic three-instruction run with a free-running consumer.
    res_ready = 1;
    clear_stats();
    run_start(5'd3);
    wait_idle(40);
    step();
    chk("basic_issue_count", issued_cnt, 3);
    chk("basic_consecutive", last_cyc - first_cyc, 2);
    chk("basic_done_pulses", done_cnt, 1);

    // Back-pressure: four issues fill the FIFO, then hold until consumer returns.
    res_ready = 0;
    clear_stats();
    run_start(5'd6);
    repeat (10) step();
    chk("bp_issued_before_hold", issued_cnt, 4);
    chk("bp_hold_valid", instr_valid, 0);
    chk("bp_hold_instruction", instruction, 0);
    chk("bp_hold_busy", busy, 1);
    res_ready = 1;
    wait_idle(40);
    chk("bp_issue_count", issued_cnt, 6);
    drain();

    // Zero-length start does nothing; start and program writes mid-run are ignored.
    clear_stats();
    run_start(5'd0);
    repeat (3) step();
    chk("len0_busy", busy, 0);
    chk("len0_done", done_cnt, 0);
    run_start(5'd8);
    step();
    run_start(5'd2);
    prog_write(4'd0, 32'hDEAD_BEEF);
    wait_idle(60);
    chk("midstart_issue_count", issued_cnt, 8);
    chk("midstart_done_pulses", done_cnt, 1);
    clear_stats();
    run_start(5'd1);
    wait_idle(20);
    chk("prog_kept_issue_count", issued_cnt, 1);

    // Reset mid-run after two issues, then rerun from index 0.
    res_ready = 0;
    clear_stats();
    run_start(5'd8);
    wait_issued(2);
    reset = 0;
    #1;
    chk("mid_rst_instr_valid", instr_valid, 0);
    chk("mid_rst_instruction", instruction, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_alu", res_alu, 0);
    chk("mid_rst_res_mem", res_mem, 0);
    chk("mid_rst_res_idx", res_idx, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_issue.delete();
    exp_res.delete();
    done_pending = 0;
    prev_sz = 0;
    step();
    reset = 1;
    res_ready = 1;
    clear_stats();
    run_start(5'd5);
    wait_idle(40);
    chk("rerun_issue_count", issued_cnt, 5);
    drain();

    // Sixteen-word run: hold count at three with push+pop each cycle, pointers wrap.
    res_ready = 0;
    clear_stats();
    run_start(5'd16);
    wait_issued(3);
    res_ready = 1;
    wait_idle(60);
    chk("wrap_issue_count", issued_cnt, 16);
    chk("wrap_consecutive", last_cyc - first_cyc, 15);
    drain();

    // Randomized programs, lengths (including saturation) and consumer stalls.
    for (int r = 0; r < 6; r++) begin
      int len;
      for (int k = 0; k < 3; k++) prog_write(4'($urandom_range(0, 15)), $urandom);
      len = $urandom_range(1, 31);
      clear_stats();
      rand_ready = 1;
      run_start(5'(len));
      wait_idle(400);
      chk("rand_issue_count", issued_cnt, (len > 16) ? 16 : len);
      chk("rand_done_pulses", done_cnt, 1);
      drain();
    end

    chk("final_issue_queue_empty", exp_issue.size(), 0);
    chk("final_result_queue_empty", exp_res.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
